// File: rtl/cache_sa_pkg.sv
// cache_sa shared types: FSM states, line metadata, address-field widths.
// Stats ports are built only with CACHE_STATS_EN defined.
package cache_sa_pkg;

  localparam int TAG_MAX = 16;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, REFILL, RESP, FLUSH
  } state_t;

  typedef struct packed {
    logic [TAG_MAX-1:0] tag;
    logic               valid;
    logic               dirty;
  } meta_t;

  function automatic int word_w(int wpb);
    return $clog2(wpb);
  endfunction

  function automatic int off_w(int wpb);
    return $clog2(wpb) + 2;
  endfunction

  function automatic int tag_w(int aw, int iw, int wpb);
    return aw - iw - off_w(wpb);
  endfunction

  function automatic int way_w(int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_sa_lru.sv
// cache_sa_lru: per-set true-LRU ages, update on access and victim select.
// Build option CACHE_STATS_EN does not affect this block.
module cache_sa_lru
  import cache_sa_pkg::*;
#(
  parameter int WAYS    = 2,
  parameter int INDEX_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     touch,
  input  logic [INDEX_W-1:0]       touch_set,
  input  logic [way_w(WAYS)-1:0]   touch_way,
  input  logic [INDEX_W-1:0]       look_set,
  output logic [way_w(WAYS)-1:0]   victim
);

  localparam int SETS = 1 << INDEX_W;
  localparam int WW   = way_w(WAYS);

  if (WAYS == 1) begin : g_one
    assign victim = '0;
  end else begin : g_lru
    // age 0 = most recent; ages converge to a permutation once every way is used
    logic [WW-1:0] age [SETS][WAYS];
    logic [WW-1:0] old;

    assign old = age[touch_set][touch_way];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            age[s][w] <= '0;
      end else if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (w == int'(touch_way))
            age[touch_set][w] <= '0;
          else if (age[touch_set][w] <= old &&
                   age[touch_set][w] != WW'(WAYS-1))
            age[touch_set][w] <= age[touch_set][w] + 1'b1;
        end
      end
    end

    always_comb begin
      logic [WW-1:0] best;
      best = '0;
      for (int w = 1; w < WAYS; w++)
        if (age[look_set][w] > age[look_set][best])
          best = WW'(w);
      victim = best;
    end
  end

endmodule

// File: rtl/cache_sa.sv
// cache_sa: write-back, write-allocate set-associative cache with flush.
// Define CACHE_STATS_EN to add saturating stat_hits/stat_misses outputs.
module cache_sa
  import cache_sa_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int INDEX_W         = 4,
  parameter int WAYS            = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WD_W  = word_w(WORDS_PER_BLOCK);
  localparam int TAG_W = tag_w(ADDR_W, INDEX_W, WORDS_PER_BLOCK);
  localparam int WW    = way_w(WAYS);
  localparam logic [WD_W-1:0]    LAST_WD  = WD_W'(WORDS_PER_BLOCK-1);
  localparam logic [INDEX_W-1:0] LAST_SET = '1;
  localparam logic [WW-1:0]      LAST_WAY = WW'(WAYS-1);

  state_t state, state_n;
  meta_t  meta [WAYS][SETS];
  logic [DATA_W-1:0] data [WAYS][SETS][WORDS_PER_BLOCK];

  logic              req_we;
  logic [ADDR_W-3:0] req_wa;
  logic [DATA_W-1:0] req_wdata;
  logic [WW-1:0]     vway, fway;
  logic [WD_W-1:0]   cnt;
  logic              busy;
  logic [INDEX_W-1:0] fset;

  logic [WD_W-1:0]    req_wd;
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic unused;

  assign req_wd  = req_wa[WD_W-1:0];
  assign req_idx = req_wa[WD_W +: INDEX_W];
  assign req_tag = req_wa[WD_W+INDEX_W +: TAG_W];
  assign unused  = ^cpu_addr[1:0];

  logic hit, inv;
  logic [WW-1:0] hit_way, inv_way, lru_way, victim;

  always_comb begin
    hit = 1'b0; hit_way = '0;
    inv = 1'b0; inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (meta[w][req_idx].valid &&
          meta[w][req_idx].tag == TAG_MAX'(req_tag)) begin
        hit = 1'b1; hit_way = WW'(w);
      end
      if (!meta[w][req_idx].valid) begin
        inv = 1'b1; inv_way = WW'(w);
      end
    end
  end

  assign victim = inv ? inv_way : lru_way;

  cache_sa_lru #(.WAYS(WAYS), .INDEX_W(INDEX_W)) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .touch     ((state == LOOKUP && hit) || state == RESP),
    .touch_set (req_idx),
    .touch_way ((state == RESP) ? vway : hit_way),
    .look_set  (req_idx),
    .victim    (lru_way)
  );

  // one word-transfer engine shared by WB, REFILL and flush write-back
  logic flush_wb, x_act, issue, got, last;
  logic [WW-1:0] x_way;
  logic [INDEX_W-1:0] x_set;
  logic [TAG_W-1:0] x_tag;

  assign flush_wb = meta[fway][fset].valid && meta[fway][fset].dirty;
  assign x_act = state == WB || state == REFILL ||
                 (state == FLUSH && flush_wb);
  assign x_way = (state == FLUSH) ? fway : vway;
  assign x_set = (state == FLUSH) ? fset : req_idx;
  assign x_tag = (state == REFILL) ? req_tag
                                   : meta[x_way][x_set].tag[TAG_W-1:0];
  assign issue = x_act && !busy && mem_ready;
  assign got   = busy && mem_done;
  assign last  = got && cnt == LAST_WD;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (cpu_req) state_n = LOOKUP;
        else if (flush_req) state_n = FLUSH;
      LOOKUP:
        if (hit) state_n = IDLE;
        else if (meta[victim][req_idx].valid &&
                 meta[victim][req_idx].dirty) state_n = WB;
        else state_n = REFILL;
      WB:     if (last) state_n = REFILL;
      REFILL: if (last) state_n = RESP;
      RESP:   state_n = IDLE;
      FLUSH:
        if (!flush_wb && fset == LAST_SET && fway == LAST_WAY)
          state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_we <= 1'b0; req_wa <= '0; req_wdata <= '0;
      vway <= '0; fway <= '0; fset <= '0;
      cnt <= '0; busy <= 1'b0;
      cpu_ready <= 1'b0; cpu_hit <= 1'b0; cpu_rdata <= '0;
      flush_done <= 1'b0;
      mem_req <= 1'b0; mem_we <= 1'b0;
      mem_addr <= '0; mem_wdata <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          meta[w][s] <= '0;
    end else begin
      state <= state_n;
      cpu_ready <= 1'b0;
      cpu_hit <= 1'b0;
      flush_done <= 1'b0;
      mem_req <= 1'b0;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= state != REFILL;
        mem_addr  <= ADDR_W'({x_tag, x_set, cnt});
        mem_wdata <= data[x_way][x_set][cnt];
        busy      <= 1'b1;
      end
      if (got) begin
        busy <= 1'b0;
        cnt  <= cnt + 1'b1;
      end
      unique case (state)
        IDLE:
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_wa    <= cpu_addr[ADDR_W-1:2];
            req_wdata <= cpu_wdata;
          end
        LOOKUP: begin
          vway <= victim;
          if (hit) begin
            cpu_ready <= 1'b1;
            cpu_hit   <= 1'b1;
            if (req_we) meta[hit_way][req_idx].dirty <= 1'b1;
            else cpu_rdata <= data[hit_way][req_idx][req_wd];
          end
        end
        REFILL:
          if (last)
            meta[vway][req_idx] <= '{tag: TAG_MAX'(req_tag),
                                     valid: 1'b1, dirty: 1'b0};
        RESP: begin
          cpu_ready <= 1'b1;
          if (req_we) meta[vway][req_idx].dirty <= 1'b1;
          else cpu_rdata <= data[vway][req_idx][req_wd];
        end
        FLUSH:
          if (flush_wb) begin
            if (last) meta[fway][fset].dirty <= 1'b0;
          end else begin
            meta[fway][fset].valid <= 1'b0;
            fway <= fway + 1'b1;
            if (fway == LAST_WAY) begin
              fway <= '0;
              fset <= fset + 1'b1;
              if (fset == LAST_SET) flush_done <= 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

  // data storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (state == REFILL && got)
      data[vway][req_idx][cnt] <= mem_rdata;
    if (state == LOOKUP && hit && req_we)
      data[hit_way][req_idx][req_wd] <= req_wdata;
    if (state == RESP && req_we)
      data[vway][req_idx][req_wd] <= req_wdata;
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (state == LOOKUP && hit && stat_hits != '1)
        stat_hits <= stat_hits + 1'b1;
      if (state == RESP && stat_misses != '1)
        stat_misses <= stat_misses + 1'b1;
    end
  end
`endif

endmodule
